// File: rtl/dcache_sa.sv
`default_nettype none
// ============================================================================
// Module   : dcache_sa
// Brief    : N-way set-associative, write-back, write-allocate L1 data cache.
//            Optional perf counters are built when DCACHE_PERF_COUNTERS_EN is defined.
//            pipe_req_size: 0=BYTE 1=HALF 2=WORD; *_type: 0=LOAD 1=STORE.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_sa #(
  parameter int LINE_SIZE  = 16,
  parameter int CACHE_SIZE = 256,
  parameter int XLEN       = 32,
  parameter int NUM_WAYS   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pipe_req_address,
  input  logic [1:0]      pipe_req_size,
  input  logic            pipe_req_type,
  input  logic            pipe_req_valid,
  input  logic [XLEN-1:0] pipe_word_to_store,
  output logic [XLEN-1:0] pipe_fetched_word,
  output logic            pipe_fetched_word_valid,
  output logic            pipe_misaligned,
  output logic [XLEN-1:0] l2_req_address,
  output logic            l2_req_type,
  output logic            l2_req_valid,
  output logic [XLEN-1:0] l2_word_to_store,
  input  logic [XLEN-1:0] l2_fetched_word,
  input  logic            l2_fetched_word_valid
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_hits,
  output logic [31:0]     perf_misses,
  output logic [31:0]     perf_writebacks
`endif
);

  localparam int c_NUM_SETS  = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
  localparam int c_WPL       = LINE_SIZE / 4;
  localparam int c_OFF_W     = $clog2(LINE_SIZE);
  localparam int c_IDX_BITS  = $clog2(c_NUM_SETS);
  localparam int c_IDX_W     = (c_IDX_BITS > 0) ? c_IDX_BITS : 1;
  localparam int c_TAG_W     = XLEN - c_OFF_W - c_IDX_BITS;
  localparam int c_WOFF_BITS = c_OFF_W - 2;
  localparam int c_WOFF_W    = (c_WOFF_BITS > 0) ? c_WOFF_BITS : 1;
  localparam int c_WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [1:0]          c_SIZE_BYTE = 2'd0;
  localparam logic [1:0]          c_SIZE_HALF = 2'd1;
  localparam logic                c_OP_STORE  = 1'b1;
  localparam logic [c_WOFF_W-1:0] c_LAST      = c_WOFF_W'(c_WPL - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_RESPOND   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_FILL      = 3'd4
  } state_e;

  state_e r_state, w_state_next;

  logic [XLEN-1:0]     r_addr, r_wdata, r_resp;
  logic [1:0]          r_size;
  logic                r_type, r_mis, r_first;
  logic [c_WOFF_W-1:0] r_cnt;
  logic [c_WAY_W-1:0]  r_victim;
  logic                r_pipe_valid, r_pipe_mis;
  logic [XLEN-1:0]     r_pipe_word;

  logic                r_valid [c_NUM_SETS][NUM_WAYS];
  logic                r_dirty [c_NUM_SETS][NUM_WAYS];
  logic [c_TAG_W-1:0]  r_tag   [c_NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     r_data  [c_NUM_SETS][NUM_WAYS][c_WPL];
  logic [c_WAY_W-1:0]  r_ptr   [c_NUM_SETS];

  logic [c_IDX_W-1:0]  w_idx;
  logic [c_WOFF_W-1:0] w_woff;
  logic [c_TAG_W-1:0]  w_tag;

  generate
    if (c_IDX_BITS > 0) begin : g_idx
      assign w_idx = r_addr[c_OFF_W +: c_IDX_W];
    end else begin : g_idx_none
      assign w_idx = '0;
    end
    if (c_WOFF_BITS > 0) begin : g_woff
      assign w_woff = r_addr[2 +: c_WOFF_W];
    end else begin : g_woff_none
      assign w_woff = '0;
    end
  endgenerate

  assign w_tag = r_addr[XLEN-1 -: c_TAG_W];

  // Tag match and victim choice both look at the latched request's set.
  logic               w_hit, w_inv;
  logic [c_WAY_W-1:0] w_hit_way, w_inv_way, w_victim;
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_WAY_W'(w);
      end
      if (!w_inv && !r_valid[w_idx][w]) begin
        w_inv     = 1'b1;
        w_inv_way = c_WAY_W'(w);
      end
    end
    w_victim = w_inv ? w_inv_way : r_ptr[w_idx];
  end

  logic            w_victim_dirty;
  logic [XLEN-1:0] w_hit_word, w_lane, w_load_word, w_mask, w_merged;
  logic [4:0]      w_shift;
  assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
  assign w_hit_word     = r_data[w_idx][w_hit_way][w_woff];
  assign w_shift        = {r_addr[1:0], 3'b000};
  assign w_lane         = w_hit_word >> w_shift;

  always_comb begin
    w_load_word = w_lane;
    w_mask      = '1;
    if (r_size == c_SIZE_BYTE) begin
      w_load_word = XLEN'(w_lane[7:0]);
      w_mask      = XLEN'(32'h0000_00FF) << w_shift;
    end else if (r_size == c_SIZE_HALF) begin
      w_load_word = XLEN'(w_lane[15:0]);
      w_mask      = XLEN'(32'h0000_FFFF) << w_shift;
    end
    w_merged = (w_hit_word & ~w_mask) | ((r_wdata << w_shift) & w_mask);
  end

  logic w_mis_in, w_accept, w_lookup, w_l2_ack, w_wb_done, w_fill_done;
  assign w_mis_in = ((pipe_req_size == c_SIZE_HALF) && pipe_req_address[0]) ||
                    ((pipe_req_size != c_SIZE_BYTE) && (pipe_req_size != c_SIZE_HALF) &&
                     (pipe_req_address[1:0] != 2'b00));
  // While the completion pulse is up the pipe has not yet retired its request.
  assign w_accept    = (r_state == S_IDLE) && pipe_req_valid && !r_pipe_valid;
  assign w_lookup    = (r_state == S_LOOKUP);
  assign w_l2_ack    = l2_fetched_word_valid && (r_cnt == c_LAST);
  assign w_wb_done   = (r_state == S_WRITEBACK) && w_l2_ack;
  assign w_fill_done = (r_state == S_FILL) && w_l2_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_next = w_mis_in ? S_RESPOND : S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)               w_state_next = S_RESPOND;
        else if (w_victim_dirty) w_state_next = S_WRITEBACK;
        else                     w_state_next = S_FILL;
      end
      S_WRITEBACK: if (w_wb_done) w_state_next = S_FILL;
      S_FILL:      if (w_fill_done) w_state_next = S_LOOKUP;
      S_RESPOND:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_type       <= 1'b0;
      r_mis        <= 1'b0;
      r_first      <= 1'b0;
      r_resp       <= '0;
      r_cnt        <= '0;
      r_victim     <= '0;
      r_pipe_valid <= 1'b0;
      r_pipe_word  <= '0;
      r_pipe_mis   <= 1'b0;
    end else begin
      r_pipe_valid <= 1'b0;
      r_pipe_word  <= '0;
      r_pipe_mis   <= 1'b0;
      if (w_accept) begin
        r_addr  <= pipe_req_address;
        r_wdata <= pipe_word_to_store;
        r_size  <= pipe_req_size;
        r_type  <= pipe_req_type;
        r_mis   <= w_mis_in;
        r_first <= 1'b1;
        r_resp  <= '0;
      end
      if (w_lookup) begin
        r_first <= 1'b0;
        if (w_hit) r_resp <= (r_type == c_OP_STORE) ? '0 : w_load_word;
        else       r_victim <= w_victim;
      end
      if (((r_state == S_WRITEBACK) || (r_state == S_FILL)) && l2_fetched_word_valid)
        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
      if (r_state == S_RESPOND) begin
        r_pipe_valid <= 1'b1;
        r_pipe_word  <= r_resp;
        r_pipe_mis   <= r_mis;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < c_NUM_SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      if (w_lookup && w_hit && (r_type == c_OP_STORE))
        r_dirty[w_idx][w_hit_way] <= 1'b1;
      // Round-robin pointer moves only when a valid line had to be displaced.
      if (w_lookup && !w_hit && !w_inv)
        r_ptr[w_idx] <= (NUM_WAYS == 1) ? '0 : r_ptr[w_idx] + 1'b1;
      if (w_wb_done)
        r_dirty[w_idx][r_victim] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) && l2_fetched_word_valid)
      r_data[w_idx][r_victim][r_cnt] <= l2_fetched_word;
    if (w_fill_done)
      r_tag[w_idx][r_victim] <= w_tag;
    if (w_lookup && w_hit && (r_type == c_OP_STORE))
      r_data[w_idx][w_hit_way][w_woff] <= w_merged;
  end

  logic               w_l2_active;
  logic [c_TAG_W-1:0] w_l2_tag;
  assign w_l2_active = (r_state == S_WRITEBACK) || (r_state == S_FILL);
  assign w_l2_tag    = (r_state == S_WRITEBACK) ? r_tag[w_idx][r_victim] : w_tag;

  assign l2_req_valid     = w_l2_active;
  assign l2_req_type      = (r_state == S_WRITEBACK);
  assign l2_req_address   = w_l2_active ?
                            ({w_l2_tag, {(c_OFF_W + c_IDX_BITS){1'b0}}} |
                             (XLEN'(w_idx) << c_OFF_W) | (XLEN'(r_cnt) << 2)) : '0;
  assign l2_word_to_store = (r_state == S_WRITEBACK) ? r_data[w_idx][r_victim][r_cnt] : '0;

  assign pipe_fetched_word       = r_pipe_word;
  assign pipe_fetched_word_valid = r_pipe_valid;
  assign pipe_misaligned         = r_pipe_mis;

`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0] r_perf_hits, r_perf_misses, r_perf_wbs;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
      r_perf_wbs    <= '0;
    end else if (w_lookup) begin
      if (r_first && w_hit && (r_perf_hits != '1))    r_perf_hits   <= r_perf_hits + 1'b1;
      if (r_first && !w_hit && (r_perf_misses != '1)) r_perf_misses <= r_perf_misses + 1'b1;
      if (!w_hit && w_victim_dirty && (r_perf_wbs != '1)) r_perf_wbs <= r_perf_wbs + 1'b1;
    end
  end
  assign perf_hits       = r_perf_hits;
  assign perf_misses     = r_perf_misses;
  assign perf_writebacks = r_perf_wbs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_sa
// Brief    : Self-checking bench for dcache_sa: directed vectors, reset abort,
//            and random traffic against a flat-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_sa;

  localparam logic [1:0] c_SZ_B = 2'd0;
  localparam logic [1:0] c_SZ_H = 2'd1;
  localparam logic [1:0] c_SZ_W = 2'd2;
  localparam logic       c_LD   = 1'b0;
  localparam logic       c_ST   = 1'b1;
  localparam int         c_WAYS = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] pipe_req_address, pipe_word_to_store, pipe_fetched_word;
  logic [1:0]  pipe_req_size;
  logic        pipe_req_type, pipe_req_valid, pipe_fetched_word_valid, pipe_misaligned;
  logic [31:0] l2_req_address, l2_word_to_store, l2_fetched_word;
  logic        l2_req_type, l2_req_valid, l2_fetched_word_valid;

  dcache_sa dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .pipe_req_address        (pipe_req_address),
    .pipe_req_size           (pipe_req_size),
    .pipe_req_type           (pipe_req_type),
    .pipe_req_valid          (pipe_req_valid),
    .pipe_word_to_store      (pipe_word_to_store),
    .pipe_fetched_word       (pipe_fetched_word),
    .pipe_fetched_word_valid (pipe_fetched_word_valid),
    .pipe_misaligned         (pipe_misaligned),
    .l2_req_address          (l2_req_address),
    .l2_req_type             (l2_req_type),
    .l2_req_valid            (l2_req_valid),
    .l2_word_to_store        (l2_word_to_store),
    .l2_fetched_word         (l2_fetched_word),
    .l2_fetched_word_valid   (l2_fetched_word_valid)
  );

  // L2 model: word memory, acks combinationally while ack_en is high.
  logic [31:0] mem [4096];
  logic        ack_en;
  logic        rand_ack = 1'b0;
  int          l2_total;
  logic [31:0] log_addr [$];
  logic        log_type [$];
  logic [31:0] log_data [$];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign l2_fetched_word       = mem[l2_req_address[13:2]];
  assign l2_fetched_word_valid = l2_req_valid & ack_en;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    mem[12'h400] = 32'hDEAD_BEEF;
    l2_total = 0;
    forever begin
      @(negedge clk);
      if (l2_req_valid && ack_en) begin
        l2_total++;
        log_addr.push_back(l2_req_address);
        log_type.push_back(l2_req_type);
        log_data.push_back(l2_word_to_store);
        if (l2_req_type) mem[l2_req_address[13:2]] = l2_word_to_store;
      end
    end
  end

  initial begin
    ack_en = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ack_en = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input logic ty,
                        input logic [31:0] wd, output logic [31:0] word,
                        output logic mis, output int edges, output int l2n);
    int   start;
    logic done;
    start = l2_total;
    done  = 1'b0;
    edges = 0;
    word  = '0;
    mis   = 1'b0;
    pipe_req_address   = a;
    pipe_req_size      = sz;
    pipe_req_type      = ty;
    pipe_word_to_store = wd;
    pipe_req_valid     = 1'b1;
    for (int k = 1; k <= 400 && !done; k++) begin
      @(posedge clk);
      #1;
      if (pipe_fetched_word_valid) begin
        done  = 1'b1;
        edges = k;
        word  = pipe_fetched_word;
        mis   = pipe_misaligned;
      end
    end
    check("req_completed", 32'(done), 32'd1);
    l2n = l2_total - start;
    pipe_req_valid = 1'b0;
    @(posedge clk);
    #1;
    if (done) check("pulse_one_cycle", 32'(pipe_fetched_word_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        ty;
    logic [31:0] wd;
    logic [31:0] exp_word;
    logic        exp_mis;
    int          exp_l2;
    int          exp_edges;
  } vec_t;

  vec_t vt [14];

  // Reference model: flat memory view plus per-set tag/valid/dirty/pointer.
  logic [31:0] gw [4096];
  logic        mv [8][c_WAYS];
  logic        md [8][c_WAYS];
  logic [24:0] mt [8][c_WAYS];
  int          mp [8];

  initial begin
    logic [31:0] got;
    logic        gmis;
    int          edges, l2n, lstart, s, hit, vic, sh, el2;
    logic [31:0] a, wd, ew, mask;
    logic [1:0]  sz;
    logic        ty, emis;

    reset_n = 1'b0;
    pipe_req_address = '0; pipe_req_size = '0; pipe_req_type = 1'b0;
    pipe_req_valid = 1'b0; pipe_word_to_store = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pipe_valid", 32'(pipe_fetched_word_valid), 32'd0);
    check("rst_pipe_mis",   32'(pipe_misaligned), 32'd0);
    check("rst_pipe_word",  pipe_fetched_word, 32'd0);
    check("rst_l2_valid",   32'(l2_req_valid), 32'd0);
    check("rst_l2_addr",    l2_req_address, 32'd0);
    check("rst_l2_type",    32'(l2_req_type), 32'd0);
    check("rst_l2_wdata",   l2_word_to_store, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    vt[0]  = '{32'h1000, c_SZ_W, c_LD, 32'h0,        32'hDEAD_BEEF, 1'b0, 4, 8};
    vt[1]  = '{32'h1000, c_SZ_W, c_LD, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 3};
    vt[2]  = '{32'h1003, c_SZ_B, c_LD, 32'h0,        32'h0000_00DE, 1'b0, 0, 3};
    vt[3]  = '{32'h1002, c_SZ_H, c_LD, 32'h0,        32'h0000_DEAD, 1'b0, 0, 3};
    vt[4]  = '{32'h1000, c_SZ_B, c_LD, 32'h0,        32'h0000_00EF, 1'b0, 0, 3};
    vt[5]  = '{32'h1001, c_SZ_B, c_ST, 32'h55,       32'h0,         1'b0, 0, 3};
    vt[6]  = '{32'h1000, c_SZ_W, c_LD, 32'h0,        32'hDEAD_55EF, 1'b0, 0, 3};
    vt[7]  = '{32'h1001, c_SZ_H, c_LD, 32'h0,        32'h0,         1'b1, 0, 2};
    vt[8]  = '{32'h1002, c_SZ_W, c_ST, 32'h1234_5678, 32'h0,        1'b1, 0, 2};
    vt[9]  = '{32'h1000, c_SZ_W, c_LD, 32'h0,        32'hDEAD_55EF, 1'b0, 0, 3};
    vt[10] = '{32'h2000, c_SZ_W, c_LD, 32'h0,        init_word(32'h800), 1'b0, 4, 8};
    vt[11] = '{32'h3000, c_SZ_W, c_LD, 32'h0,        init_word(32'hC00), 1'b0, 8, 12};
    vt[12] = '{32'h1000, c_SZ_W, c_LD, 32'h0,        32'hDEAD_55EF, 1'b0, 4, 8};
    vt[13] = '{32'h3000, c_SZ_W, c_LD, 32'h0,        init_word(32'hC00), 1'b0, 0, 3};

    for (int i = 0; i < 14; i++) begin
      lstart = log_addr.size();
      do_req(vt[i].addr, vt[i].sz, vt[i].ty, vt[i].wd, got, gmis, edges, l2n);
      check($sformatf("vec%0d_word", i),  got, vt[i].exp_word);
      check($sformatf("vec%0d_mis", i),   32'(gmis), 32'(vt[i].exp_mis));
      check($sformatf("vec%0d_l2n", i),   32'(l2n), 32'(vt[i].exp_l2));
      check($sformatf("vec%0d_edges", i), 32'(edges), 32'(vt[i].exp_edges));
      if (i == 1) check("vec1_first_fill_addr", log_addr[lstart - 4], 32'h1000);
      if (i == 11) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("wb%0d_addr", k), log_addr[lstart + k], 32'h1000 + 32'(4 * k));
          check($sformatf("wb%0d_type", k), 32'(log_type[lstart + k]), 32'd1);
          check($sformatf("fill%0d_addr", k), log_addr[lstart + 4 + k], 32'h3000 + 32'(4 * k));
          check($sformatf("fill%0d_type", k), 32'(log_type[lstart + 4 + k]), 32'd0);
        end
        check("wb0_data", log_data[lstart], 32'hDEAD_55EF);
      end
    end

    // Reset while the second fill word of 0x2000 is outstanding.
    lstart = l2_total;
    pipe_req_address = 32'h2000; pipe_req_size = c_SZ_W; pipe_req_type = c_LD;
    pipe_req_valid = 1'b1;
    for (int k = 0; k < 50 && l2_total == lstart; k++) @(negedge clk);
    check("abort_fill_started", 32'(l2_total - lstart), 32'd1);
    @(posedge clk);
    #2;
    check("abort_word1_addr", l2_req_address, 32'h2004);
    check("abort_word1_valid", 32'(l2_req_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_l2_valid_drop", 32'(l2_req_valid), 32'd0);
    pipe_req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_req(32'h1000, c_SZ_W, c_LD, 32'h0, got, gmis, edges, l2n);
    check("post_rst_word", got, 32'hDEAD_55EF);
    check("post_rst_l2n", 32'(l2n), 32'd4);

    // Random traffic from a cold cache.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4096; i++) gw[i] = mem[i];
    for (int i = 0; i < 8; i++) begin
      mp[i] = 0;
      for (int w = 0; w < c_WAYS; w++) begin
        mv[i][w] = 1'b0; md[i][w] = 1'b0; mt[i][w] = '0;
      end
    end
    rand_ack = 1'b1;

    for (int n = 0; n < 400; n++) begin
      a  = 32'h1000 + 32'($urandom_range(0, 511));
      sz = 2'($urandom_range(0, 2));
      ty = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == c_SZ_H) a[0] = 1'b0;
        if (sz == c_SZ_W) a[1:0] = 2'b00;
      end
      emis = ((sz == c_SZ_H) && a[0]) || ((sz == c_SZ_W) && (a[1:0] != 2'b00));
      ew = '0;
      el2 = 0;
      if (!emis) begin
        s = int'(a[6:4]);
        hit = -1;
        for (int w = 0; w < c_WAYS; w++) if (mv[s][w] && mt[s][w] == a[31:7]) hit = w;
        if (hit < 0) begin
          vic = -1;
          for (int w = c_WAYS - 1; w >= 0; w--) if (!mv[s][w]) vic = w;
          if (vic < 0) begin
            vic = mp[s];
            mp[s] = (mp[s] + 1) % c_WAYS;
          end
          el2 = (mv[s][vic] && md[s][vic]) ? 8 : 4;
          mv[s][vic] = 1'b1; md[s][vic] = 1'b0; mt[s][vic] = a[31:7];
          hit = vic;
        end
        sh = 8 * int'(a[1:0]);
        mask = (sz == c_SZ_B) ? 32'hFF : (sz == c_SZ_H) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (ty == c_ST) begin
          gw[a[13:2]] = (gw[a[13:2]] & ~(mask << sh)) | ((wd & mask) << sh);
          md[s][hit] = 1'b1;
        end else begin
          ew = (gw[a[13:2]] >> sh) & mask;
        end
      end
      do_req(a, sz, ty, wd, got, gmis, edges, l2n);
      check($sformatf("rnd%0d_word a=%h sz=%0d ty=%0d", n, a, sz, ty), got, ew);
      check($sformatf("rnd%0d_mis", n), 32'(gmis), 32'(emis));
      check($sformatf("rnd%0d_l2n", n), 32'(l2n), 32'(el2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_sa.md
Name: dcache_sa

Overview:
N-way set-associative, write-back, write-allocate L1 data cache. It is the parametrised successor to the direct-mapped, load-only dcache. The block sits between the pipeline load/store unit and the L2, using the same word-granular pipe_*/l2_* interface. New relative to the direct-mapped cache: configurable associativity, STORE support with byte/half/word merging, dirty-line writeback, round-robin replacement and misalignment detection.

Parameters:
LINE_SIZE, 16, bytes per line (power of 2, >=4)
CACHE_SIZE, 256, total data bytes
XLEN, 32, address/data width (fixed 32 in this revision)
NUM_WAYS, 2, associativity (power of 2, >=1); NUM_SETS = CACHE_SIZE/(LINE_SIZE*NUM_WAYS), WORDS_PER_LINE = LINE_SIZE/4

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
pipe_req_address  in  XLEN  byte address
pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD
pipe_req_type  in  memory_operation_e  LOAD/STORE
pipe_req_valid  in  1  request valid, held until completion seen
pipe_word_to_store  in  XLEN  store data, right-aligned
pipe_fetched_word  out  XLEN  load result, zero-extended
pipe_fetched_word_valid  out  1  one-cycle completion pulse (loads and stores)
pipe_misaligned  out  1  qualifies completion pulse: request rejected
l2_req_address  out  XLEN  word-aligned L2 address
l2_req_type  out  memory_operation_e  LOAD (fill) / STORE (writeback)
l2_req_valid  out  1  L2 request, held until acknowledged
l2_word_to_store  out  XLEN  writeback data
l2_fetched_word  in  XLEN  fill data
l2_fetched_word_valid  in  1  L2 ack for LOAD and STORE; data ignored on STORE

Behaviour:
- Address split: offset = addr[log2(LINE_SIZE)-1:0], index = next log2(NUM_SETS) bits, tag = remainder.
- Per line: valid, dirty, tag, WORDS_PER_LINE data words. Per set: round-robin victim pointer.
- Reset (async): state IDLE; all valid/dirty bits = 0; pointers = 0; all outputs = 0. l2_req_valid drops in the same instant. Reset mid-transaction aborts it with no partial line marked valid.
- FSM: IDLE -> LOOKUP -> {RESPOND | WRITEBACK | FILL}; WRITEBACK -> FILL -> LOOKUP; RESPOND -> IDLE.
- IDLE: on pipe_req_valid, latch address/size/type/data. Misaligned request (HALF with addr[0]=1, WORD with addr[1:0]!=0) goes directly to RESPOND with pipe_misaligned=1 and pipe_fetched_word=0; no state change, no L2 traffic.
- LOOKUP: compare tag against all ways of the set.
  - Hit LOAD: extract byte/half/word at the offset, zero-extend.
  - Hit STORE: merge byte enables into the word and set dirty.
  - Either hit goes to RESPOND.
- Hit latency: pipe_fetched_word_valid rises at the 2nd rising edge after the acceptance edge.
- Victim selection: lowest-numbered invalid way. If all ways are valid, the pointer way is chosen and the pointer increments modulo NUM_WAYS. The pointer changes only in that case.
- Dirty victim: WRITEBACK issues WORDS_PER_LINE L2 STOREs, word 0 first. Each STORE holds l2_req_valid/address/data until an edge with l2_fetched_word_valid=1; the next word starts the following cycle. Dirty bit clears after the last word.
- FILL: WORDS_PER_LINE L2 LOADs, word 0 first. Each LOAD is captured on an edge with l2_fetched_word_valid=1. After the last word: valid=1, dirty=0, tag written. Then re-LOOKUP, which now hits (STORE merge happens there).
- RESPOND: pipe_fetched_word_valid=1 for exactly one cycle; STORE responses drive pipe_fetched_word=0. The next request is not accepted until IDLE (one idle cycle minimum).
- l2_fetched_word_valid outside an active L2 request is ignored.
- pipe_req_valid deasserting mid-transaction: the transaction completes anyway.

Optional Feature:
DCACHE_PERF_COUNTERS_EN
- Defined: adds outputs perf_hits, perf_misses, perf_writebacks (32 bits each), reset to 0 and saturating at all-ones.
  - perf_hits increments on a first-LOOKUP hit.
  - perf_misses increments on a first-LOOKUP miss.
  - perf_writebacks increments once per evicted dirty line.
  - Misaligned requests count nowhere.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
(Defaults: NUM_SETS=8, index=addr[6:4]; memory[0x1000]=0xDEADBEEF; L2 acks combinationally.)
1. Cold LOAD WORD 0x1000 -> L2 LOADs at 0x1000, 0x1004, 0x1008, 0x100C; response 0xDEADBEEF. Repeat -> no L2 request; valid 2 edges after acceptance.
2. LOAD BYTE 0x1003 -> 0x000000DE; LOAD HALF 0x1002 -> 0x0000DEAD; LOAD BYTE 0x1000 -> 0x000000EF.
3. STORE BYTE 0x1001 data 0x00000055 -> no L2 traffic, completion pulse. Then LOAD WORD 0x1000 -> 0xDEAD55EF.
4. After test 3, LOAD 0x2000 then LOAD 0x3000 (all set 0). Expect:
   - 0x2000 fills way1.
   - 0x3000 evicts way0: L2 STOREs 0x1000..0x100C, first data 0xDEAD55EF, then fill from 0x3000.
   - LOAD 0x1000 then misses and evicts way1 (0x2000, clean, no writeback).
5. LOAD HALF 0x1001 and STORE WORD 0x1002 -> pipe_misaligned=1 with valid, fetched word 0, no L2 request, cache contents unchanged.
6. reset_n low during the 2nd fill word -> l2_req_valid=0 immediately. After release, LOAD 0x1000 misses again (4 L2 LOADs).
